fft_ram_arbiter: RTL

Two-requester arbiter that shares the single-port FFT sample RAM (16-bit words, paired read of addr/addr+1, one-cycle registered read) between the RS5 core data port (requester 0) and the FFT butterfly engine (requester 1). Round-robin grant with bounded burst ownership, valid/ready request handshake, and a tagged response path that returns each read pair to the requester that issued it. Sits between both masters and the RAM; owns the RAM en/we/addr/data inputs.

---
 rtl/fft_ram_arbiter_pkg.sv | 28 ++
 rtl/fft_ram_arbiter_if.sv | 38 +++
 rtl/fft_ram_arbiter_rr_grant2.sv | 80 ++++++++
 rtl/fft_ram_arbiter.sv | 87 ++++++++
 4 files changed

// File: rtl/fft_ram_arbiter_pkg.sv
// rtl/fft_ram_arbiter_pkg.sv - shared types and defaults for the FFT sample RAM arbiter
//
// Purpose: requester ids, owner-state encoding, default burst limit and small
// helpers used by the grant logic and the arbiter top.
package fft_ram_arbiter_pkg;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_FFT  = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_FFT  = 2'd2
  } owner_t;

  localparam int MAX_BURST_DEFAULT = 4;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_CORE) ? REQ_FFT : REQ_CORE;
  endfunction

  function automatic owner_t owner_of(input req_id_t id);
    return (id == REQ_FFT) ? OWN_FFT : OWN_CORE;
  endfunction

endpackage

// File: rtl/fft_ram_arbiter_if.sv
// rtl/fft_ram_arbiter_if.sv - requester-side request/response bundle of the RAM arbiter
//
// Purpose: groups both requesters' request handshake and the shared tagged
// read-response path.
// Signals:
//   req_valid[1:0]  request valid, bit n = requester n (0 core, 1 FFT)
//   req_ready[1:0]  request accepted this cycle (one-hot or zero)
//   req_we[1:0]     1 = write, 0 = paired read
//   req_addr[n]     word address per requester
//   req_data[n]     write data per requester (RAM keeps low 16 bits)
//   rsp_valid[1:0]  read response pulse to the issuing requester
//   rsp_data_a/b    RAM words at addr / addr+1, qualified by rsp_valid
// Modports: master = requester side, slave = arbiter side.
interface fft_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0]                 req_we;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0] req_data;
  logic [1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]      rsp_data_a;
  logic [DATA_WIDTH-1:0]      rsp_data_b;

  modport master (
    output req_valid, req_we, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data_a, rsp_data_b
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data_a, rsp_data_b
  );

endinterface

// File: rtl/fft_ram_arbiter_rr_grant2.sv
// rtl/fft_ram_arbiter_rr_grant2.sv - two-way round-robin grant with bounded burst ownership
//
// Purpose: picks at most one of two requesters per cycle. The current owner
// keeps the RAM for up to MAX_BURST consecutive beats while the other side
// waits; a lone requester is never forced to pause.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   valid[1:0]   request valid per requester
//   grant_valid  a requester is granted this cycle (always a handshake,
//                since only a valid requester is ever granted)
//   grant_id     granted requester
module fft_ram_arbiter_rr_grant2
  import fft_ram_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic       grant_valid,
  output req_id_t    grant_id
);

  localparam int                CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]     COUNT_MAX = CW'(MAX_BURST);

  owner_t        owner;
  logic [CW-1:0] count;
  req_id_t       last_owner;
  req_id_t       cur_id;

  always_comb begin
    cur_id      = (owner == OWN_FFT) ? REQ_FFT : REQ_CORE;
    grant_valid = 1'b0;
    grant_id    = REQ_CORE;
    if (owner == OWN_IDLE) begin
      // from idle a tie goes to whoever did not own the RAM last
      if (valid == 2'b11) begin
        grant_valid = 1'b1;
        grant_id    = other_req(last_owner);
      end else if (valid[0]) begin
        grant_valid = 1'b1;
        grant_id    = REQ_CORE;
      end else if (valid[1]) begin
        grant_valid = 1'b1;
        grant_id    = REQ_FFT;
      end
    end else if (valid[cur_id] && (count < COUNT_MAX)) begin
      grant_valid = 1'b1;
      grant_id    = cur_id;
    end else if (valid[other_req(cur_id)]) begin
      grant_valid = 1'b1;
      grant_id    = other_req(cur_id);
    end else if (valid[cur_id]) begin
      // burst exhausted but nobody else wants the RAM: start a fresh burst
      grant_valid = 1'b1;
      grant_id    = cur_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_IDLE;
      count      <= '0;
      last_owner <= REQ_FFT;
    end else if (grant_valid) begin
      owner      <= owner_of(grant_id);
      last_owner <= grant_id;
      if ((owner != OWN_IDLE) && (grant_id == cur_id) && (count < COUNT_MAX)) begin
        count <= count + CW'(1);
      end else begin
        count <= CW'(1);
      end
    end else begin
      owner <= OWN_IDLE;
      count <= '0;
    end
  end

endmodule

// File: rtl/fft_ram_arbiter.sv
// rtl/fft_ram_arbiter.sv - shares the single-port FFT sample RAM between core and FFT engine
//
// Purpose: combinational round-robin grant drives the RAM in the same cycle a
// request is accepted; read handshakes leave a one-entry tag so the registered
// RAM read pair is returned the next cycle to the requester that issued it.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   bus (slave)         request handshake and tagged response for both requesters
//   ram_en, ram_we      RAM enable / write enable (zero when nothing accepted)
//   ram_addr, ram_data  RAM word address and write data (zero when idle)
//   ram_data_a/b        RAM registered read words at addr / addr+1
module fft_ram_arbiter
  import fft_ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = MAX_BURST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_ram_arbiter_if.slave      bus,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_data_a,
  input  logic [DATA_WIDTH-1:0] ram_data_b
);

  logic    grant_valid;
  req_id_t grant_id;
  logic    gid;
  logic    hs;
  logic    rsp_pend;
  req_id_t rsp_id;

  fft_ram_arbiter_rr_grant2 #(
    .MAX_BURST (MAX_BURST)
  ) u_grant (
    .clk         (clk),
    .rst         (rst),
    .valid       (bus.req_valid),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign gid = grant_id;
  // the grant is combinational on valid, so hold it off while reset is asserted
  assign hs  = grant_valid & rst;

  always_comb begin
    bus.req_ready = 2'b00;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_data      = '0;
    if (hs) begin
      bus.req_ready[gid] = 1'b1;
      ram_en             = 1'b1;
      ram_we             = bus.req_we[gid];
      ram_addr           = bus.req_addr[gid];
      ram_data           = bus.req_data[gid];
    end
  end

  // one outstanding tag suffices: the RAM answers exactly one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_pend <= 1'b0;
      rsp_id   <= REQ_CORE;
    end else begin
      rsp_pend <= hs & ~ram_we;
      rsp_id   <= grant_id;
    end
  end

  always_comb begin
    bus.rsp_valid = 2'b00;
    if (rsp_pend) begin
      bus.rsp_valid[rsp_id] = 1'b1;
    end
  end

  assign bus.rsp_data_a = ram_data_a;
  assign bus.rsp_data_b = ram_data_b;

endmodule
